// File: rtl/emif_cal_csr_pkg.sv
// Shared definitions for the EMIF calibration CSR block: register offsets,
// STATUS bit positions, the reset-sequence state enum and the DFH layout.
package emif_cal_csr_pkg;

   localparam logic [4:0] OFF_DFH     = 5'h00;
   localparam logic [4:0] OFF_CAP     = 5'h08;
   localparam logic [4:0] OFF_STATUS  = 5'h10;
   localparam logic [4:0] OFF_CONTROL = 5'h18;

   localparam int ST_BUSY_BIT  = 16;
   localparam int ST_TMO_BIT   = 17;
   localparam int ST_ACKN_BIT  = 18;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_CLR_BIT   = 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ASSERT   = 2'd1,
      S_RELEASE  = 2'd2,
      S_CAL_WAIT = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0]  dfh_type;
      logic [18:0] rsvd;
      logic        eol;
      logic [23:0] nxt_offset;
      logic [3:0]  rev;
      logic [11:0] feat_id;
   } dfh_t;

endpackage

// File: rtl/emif_cal_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous level signals,
// with a selectable reset value.
module emif_cal_sync #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   // Metastability filter: two back-to-back flops per bit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1 <= RST_VAL;
         r_s2 <= RST_VAL;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/emif_cal_csr.sv
// EMIF CSR responder: DFH/capability/status reads and the software-requested
// mem_ss reset sequence followed by a bounded wait for channel calibration.
module emif_cal_csr
   import emif_cal_csr_pkg::*;
#(
   parameter int                NUM_CH         = 4,
   parameter logic [11:0]       FEAT_ID        = 12'h009,
   parameter logic [23:0]       NXT_DFH_OFFSET = 24'h001000,
   parameter logic              DFH_EOL        = 1'b0,
   parameter logic [3:0]        FEAT_REV       = 4'h1,
   parameter logic [NUM_CH-1:0] CH_MASK        = 4'hF,
   parameter int                TIMEOUT_W      = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csr_rd,
   input  logic              csr_wr,
   input  logic [4:0]        csr_addr,
   input  logic [63:0]       csr_wdata,
   output logic [63:0]       csr_rdata,
   output logic              csr_rvalid,
   output logic              mem_ss_rst_req,
   input  logic              mem_ss_rst_ack_n,
   input  logic [NUM_CH-1:0] mem_ss_cal_success,
   input  logic [NUM_CH-1:0] mem_ss_cal_fail,
   output logic              cal_done
);

   logic              w_ack_n;
   logic [NUM_CH-1:0] w_succ;
   logic [NUM_CH-1:0] w_fail;

   emif_cal_sync #(.W(1), .RST_VAL(1'b1)) u_sync_ack (
      .i_clk(clk), .i_rst(rst), .i_d(mem_ss_rst_ack_n), .o_q(w_ack_n)
   );
   emif_cal_sync #(.W(NUM_CH), .RST_VAL({NUM_CH{1'b0}})) u_sync_succ (
      .i_clk(clk), .i_rst(rst), .i_d(mem_ss_cal_success), .o_q(w_succ)
   );
   emif_cal_sync #(.W(NUM_CH), .RST_VAL({NUM_CH{1'b0}})) u_sync_fail (
      .i_clk(clk), .i_rst(rst), .i_d(mem_ss_cal_fail), .o_q(w_fail)
   );

   state_t                r_state;
   state_t                w_next;
   logic                  w_set_tmo;
   logic [TIMEOUT_W-1:0]  r_cnt;
   logic                  r_tmo;
   logic                  r_rst_req;
   logic [63:0]           r_rdata;
   logic                  r_rvalid;
   logic [63:0]           w_rd_mux;
   logic [63:0]           w_status;
   dfh_t                  w_dfh;

   logic [4:0] w_off;
   assign w_off = {csr_addr[4:3], 3'b000};

   logic w_wr_ctrl;
   logic w_start;
   logic w_clr;
   assign w_wr_ctrl = csr_wr && (w_off == OFF_CONTROL);
   assign w_start   = w_wr_ctrl && csr_wdata[CTRL_START_BIT];
   assign w_clr     = w_wr_ctrl && csr_wdata[CTRL_CLR_BIT];

   logic w_all_ok;
   logic w_any_fail;
   logic w_cnt_max;
   assign w_all_ok   = ((w_succ & CH_MASK) == CH_MASK);
   assign w_any_fail = |(w_fail & CH_MASK);
   assign w_cnt_max  = &r_cnt;

   logic w_unused_bits;
   assign w_unused_bits = ^{csr_addr[2:0], csr_wdata[63:2]};

   // Reset-sequence state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; success takes priority over a coincident failure/timeout.
   always_comb begin
      w_next    = r_state;
      w_set_tmo = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_next = S_ASSERT;
            else         w_next = S_IDLE;
         end
         S_ASSERT: begin
            if (!w_ack_n) w_next = S_RELEASE;
            else          w_next = S_ASSERT;
         end
         S_RELEASE: begin
            if (w_ack_n) w_next = S_CAL_WAIT;
            else         w_next = S_RELEASE;
         end
         S_CAL_WAIT: begin
            if (w_all_ok) begin
               w_next = S_IDLE;
            end else if (w_any_fail || w_cnt_max) begin
               w_next    = S_IDLE;
               w_set_tmo = 1'b1;
            end else begin
               w_next = S_CAL_WAIT;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Timeout counter: cleared on RELEASE entry, saturating count in CAL_WAIT.
   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= {TIMEOUT_W{1'b0}};
      else if (r_state == S_ASSERT && w_next == S_RELEASE)
         r_cnt <= {TIMEOUT_W{1'b0}};
      else if (r_state == S_CAL_WAIT && !w_cnt_max)
         r_cnt <= r_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      else
         r_cnt <= r_cnt;
   end

   // Sticky timeout flag and registered reset request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo     <= 1'b0;
         r_rst_req <= 1'b0;
      end else begin
         if (w_set_tmo)  r_tmo <= 1'b1;
         else if (w_clr) r_tmo <= 1'b0;
         else            r_tmo <= r_tmo;
         r_rst_req <= (w_next == S_ASSERT);
      end
   end

   // Read data mux from current (pre-write) state.
   always_comb begin
      w_dfh            = '0;
      w_dfh.dfh_type   = 4'h3;
      w_dfh.eol        = DFH_EOL;
      w_dfh.nxt_offset = NXT_DFH_OFFSET;
      w_dfh.rev        = FEAT_REV;
      w_dfh.feat_id    = FEAT_ID;

      w_status                 = 64'd0;
      w_status[NUM_CH-1:0]     = w_succ;
      w_status[NUM_CH+7:8]     = w_fail;
      w_status[ST_BUSY_BIT]    = (r_state != S_IDLE);
      w_status[ST_TMO_BIT]     = r_tmo;
      w_status[ST_ACKN_BIT]    = w_ack_n;

      w_rd_mux = 64'd0;
      case (w_off)
         OFF_DFH:    w_rd_mux = w_dfh;
         OFF_CAP:    w_rd_mux[NUM_CH-1:0] = CH_MASK;
         OFF_STATUS: w_rd_mux = w_status;
         default:    w_rd_mux = 64'd0;
      endcase
   end

   // One-cycle read response; data holds until the next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 64'd0;
      end else begin
         r_rvalid <= csr_rd;
         if (csr_rd) r_rdata <= w_rd_mux;
         else        r_rdata <= r_rdata;
      end
   end

   assign csr_rdata      = r_rdata;
   assign csr_rvalid     = r_rvalid;
   assign mem_ss_rst_req = r_rst_req;
   assign cal_done       = (r_state == S_IDLE) && w_all_ok;

endmodule

// File: tb/tb_emif_cal_csr.sv
// Directed bench for emif_cal_csr: read expectations go through a scoreboard
// queue; every comparison is an immediate assertion.
module tb_emif_cal_csr;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_rd;
   logic        csr_wr;
   logic [4:0]  csr_addr;
   logic [63:0] csr_wdata;
   logic [63:0] csr_rdata;
   logic        csr_rvalid;
   logic        mem_ss_rst_req;
   logic        mem_ss_rst_ack_n;
   logic [3:0]  mem_ss_cal_success;
   logic [3:0]  mem_ss_cal_fail;
   logic        cal_done;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   localparam logic [63:0] DFH_EXP = 64'h3000_0000_1000_1009;

   emif_cal_csr #(.TIMEOUT_W(8)) dut (
      .clk(clk), .rst(rst), .csr_rd(csr_rd), .csr_wr(csr_wr),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .csr_rvalid(csr_rvalid), .mem_ss_rst_req(mem_ss_rst_req),
      .mem_ss_rst_ack_n(mem_ss_rst_ack_n),
      .mem_ss_cal_success(mem_ss_cal_success),
      .mem_ss_cal_fail(mem_ss_cal_fail), .cal_done(cal_done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input string tag, input logic [4:0] addr, input logic [63:0] exp);
      logic [63:0] e;
      exp_q.push_back(exp);
      csr_rd   = 1'b1;
      csr_addr = addr;
      cyc();
      csr_rd   = 1'b0;
      chk({tag, "_rvalid"}, {63'd0, csr_rvalid}, 64'd1);
      e = exp_q.pop_front();
      chk(tag, csr_rdata, e);
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
      csr_wr    = 1'b1;
      csr_addr  = addr;
      csr_wdata = data;
      cyc();
      csr_wr    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; csr_rd = 1'b0; csr_wr = 1'b0; csr_addr = 5'h00; csr_wdata = 64'd0;
      mem_ss_rst_ack_n = 1'b1; mem_ss_cal_success = 4'h0; mem_ss_cal_fail = 4'h0;
      wait_n(3);
      rst = 1'b0;
      chk("rst_req_reset", {63'd0, mem_ss_rst_req}, 64'd0);
      chk("rvalid_reset", {63'd0, csr_rvalid}, 64'd0);
      chk("cal_done_reset", {63'd0, cal_done}, 64'd0);

      // Identification and idle status (synchronized ack_n idles high).
      do_read("dfh", 5'h00, DFH_EXP);
      cyc();
      chk("rvalid_one_cycle", {63'd0, csr_rvalid}, 64'd0);
      chk("rdata_hold", csr_rdata, DFH_EXP);
      do_read("cap", 5'h08, 64'h0000_0000_0000_000F);
      do_read("status_idle", 5'h10, 64'h0000_0000_0004_0000);
      do_read("control_rd", 5'h18, 64'd0);

      // Full successful sequence.
      do_write(5'h18, 64'd1);
      chk("req_rise", {63'd0, mem_ss_rst_req}, 64'd1);
      mem_ss_rst_ack_n = 1'b0;
      wait_n(2);
      chk("req_hold_2", {63'd0, mem_ss_rst_req}, 64'd1);
      cyc();
      chk("req_fall_3", {63'd0, mem_ss_rst_req}, 64'd0);
      mem_ss_rst_ack_n = 1'b1;
      wait_n(3);
      do_read("status_calwait", 5'h10, 64'h0000_0000_0005_0000);
      wait_n(100);
      mem_ss_cal_success = 4'hF;
      wait_n(2);
      chk("cal_done_2", {63'd0, cal_done}, 64'd0);
      cyc();
      chk("cal_done_3", {63'd0, cal_done}, 64'd1);
      do_read("status_ok", 5'h10, 64'h0000_0000_0004_000F);

      // Timeout: one channel never calibrates.
      mem_ss_cal_success = 4'h0;
      wait_n(3);
      chk("cal_done_drop", {63'd0, cal_done}, 64'd0);
      mem_ss_cal_success = 4'h7;
      do_write(5'h18, 64'd1);
      mem_ss_rst_ack_n = 1'b0;
      wait_n(3);
      mem_ss_rst_ack_n = 1'b1;
      wait_n(258);
      do_read("status_last_wait", 5'h10, 64'h0000_0000_0005_0007);
      do_read("status_timeout", 5'h10, 64'h0000_0000_0006_0007);
      chk("cal_done_partial", {63'd0, cal_done}, 64'd0);
      do_write(5'h18, 64'd2);
      do_read("status_w1c", 5'h10, 64'h0000_0000_0004_0007);

      // Channel failure aborts the wait immediately.
      mem_ss_cal_success = 4'h0;
      wait_n(3);
      do_write(5'h18, 64'd1);
      mem_ss_rst_ack_n = 1'b0;
      wait_n(3);
      mem_ss_rst_ack_n = 1'b1;
      wait_n(8);
      mem_ss_cal_fail = 4'b0100;
      wait_n(2);
      do_read("status_fail_seen", 5'h10, 64'h0000_0000_0005_0400);
      do_read("status_fail_abort", 5'h10, 64'h0000_0000_0006_0400);
      mem_ss_cal_fail = 4'h0;
      do_write(5'h18, 64'd2);
      wait_n(2);
      do_read("status_fail_clr", 5'h10, 64'h0000_0000_0004_0000);

      // Start during ASSERT is dropped, not queued.
      do_write(5'h18, 64'd1);
      chk("req_rise2", {63'd0, mem_ss_rst_req}, 64'd1);
      do_write(5'h18, 64'd1);
      chk("req_during_assert", {63'd0, mem_ss_rst_req}, 64'd1);
      mem_ss_rst_ack_n = 1'b0;
      wait_n(3);
      chk("req_fall2", {63'd0, mem_ss_rst_req}, 64'd0);
      mem_ss_rst_ack_n = 1'b1;
      wait_n(3);
      mem_ss_cal_success = 4'hF;
      wait_n(3);
      chk("cal_done_once", {63'd0, cal_done}, 64'd1);
      wait_n(5);
      chk("no_restart_req", {63'd0, mem_ss_rst_req}, 64'd0);
      do_read("status_no_restart", 5'h10, 64'h0000_0000_0004_000F);

      // Reset while in RELEASE; the read issued alongside reset is squashed
      // (0x20 aliases to 0x00 on the 5-bit offset, which would return the DFH).
      mem_ss_cal_success = 4'h0;
      wait_n(3);
      do_write(5'h18, 64'd1);
      mem_ss_rst_ack_n = 1'b0;
      wait_n(3);
      do_read("status_release", 5'h10, 64'h0000_0000_0001_0000);
      rst = 1'b1; csr_rd = 1'b1; csr_addr = 5'h00;
      cyc();
      rst = 1'b0; csr_rd = 1'b0;
      chk("rst_mid_req", {63'd0, mem_ss_rst_req}, 64'd0);
      chk("rst_mid_rvalid", {63'd0, csr_rvalid}, 64'd0);
      chk("rst_mid_rdata", csr_rdata, 64'd0);
      do_read("status_after_rst", 5'h10, 64'h0000_0000_0004_0000);
      mem_ss_rst_ack_n = 1'b1;
      wait_n(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
